// File: rtl/disp_bcd_ctrl.sv
// disp_bcd_ctrl: serial double-dabble distance-to-BCD converter with flicker hold and newest-value coalescing
// Optional leading-zero blanking is enabled by defining DISP_LZB_EN.
module disp_bcd_ctrl #(
   parameter int HOLD_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [13:0] value,
   input  logic        value_valid,
   output logic [3:0]  dig0,
   output logic [3:0]  dig1,
   output logic [3:0]  dig2,
   output logic [3:0]  dig3,
   output logic        ovf,
   output logic        busy,
   output logic        upd_done
);
   localparam logic [1:0] S_IDLE = 2'd0, S_SHIFT = 2'd1, S_COMMIT = 2'd2, S_HOLD = 2'd3;
   localparam logic [19:0] HOLD_INIT = 20'(HOLD_CYCLES - 1);
`ifdef DISP_LZB_EN
   localparam logic [15:0] RST_DIG = 16'hFFF0;
`else
   localparam logic [15:0] RST_DIG = 16'h0000;
`endif
   logic [1:0]  state;
   logic [13:0] bin;
   logic [15:0] bcd;
   logic [15:0] adj;
   logic [15:0] disp;
   logic [15:0] digs;
   logic [3:0]  bit_cnt;
   logic [19:0] hold_cnt;
   logic        ovf_flag;
   logic [13:0] pend;
   logic        pend_v;
   logic        hold_exit;
   logic        capture;
   logic [13:0] cap_val;
   genvar i;
   generate
      for (i = 0; i < 4; i++) begin : g_adj
         assign adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
      end
   endgenerate
   assign hold_exit = state == S_HOLD && hold_cnt == 20'd0;
   assign capture   = (state == S_IDLE && value_valid) || (hold_exit && (value_valid || pend_v));
   assign cap_val   = value_valid ? value : pend;
   assign busy      = state != S_IDLE;
   assign {dig3, dig2, dig1, dig0} = digs;
   // blanking mask applied only at commit; overflow overrides everything
   always_comb begin
      disp = bcd;
`ifdef DISP_LZB_EN
      if (bcd[15:12] == 4'd0) disp[15:12] = 4'hF;
      if (bcd[15:8] == 8'd0) disp[11:8] = 4'hF;
      if (bcd[15:4] == 12'd0) disp[7:4] = 4'hF;
`endif
      if (ovf_flag) disp = 16'hFFFF;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         bin      <= '0;
         bcd      <= '0;
         bit_cnt  <= '0;
         hold_cnt <= '0;
         ovf_flag <= 1'b0;
         pend     <= '0;
         pend_v   <= 1'b0;
         digs     <= RST_DIG;
         ovf      <= 1'b0;
         upd_done <= 1'b0;
      end else begin
         upd_done <= 1'b0;
         if (capture) begin
            bin      <= cap_val;
            ovf_flag <= cap_val > 14'd9999;
            bcd      <= '0;
            bit_cnt  <= '0;
            state    <= S_SHIFT;
         end else begin
            case (state)
               S_SHIFT: begin
                  {bcd, bin} <= {adj[14:0], bin, 1'b0};
                  bit_cnt    <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd13) state <= S_COMMIT;
               end
               S_COMMIT: begin
                  digs     <= disp;
                  ovf      <= ovf_flag;
                  upd_done <= 1'b1;
                  hold_cnt <= HOLD_INIT;
                  state    <= S_HOLD;
               end
               S_HOLD: begin
                  if (hold_exit) state <= S_IDLE;
                  else hold_cnt <= hold_cnt - 20'd1;
               end
               default: state <= S_IDLE;
            endcase
         end
         // exit cycle consumes (or supersedes) the pending value
         if (hold_exit) pend_v <= 1'b0;
         else if (value_valid && state != S_IDLE) begin
            pend   <= value;
            pend_v <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_disp_bcd_ctrl.sv
// tb_disp_bcd_ctrl: scoreboard bench for disp_bcd_ctrl with HOLD_CYCLES=4
// Honors DISP_LZB_EN in its reference model when defined.
module tb_disp_bcd_ctrl;
   typedef struct {
      logic [16:0] exp;
      int          due;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [13:0] value = '0;
   logic        value_valid = 1'b0;
   logic [3:0]  dig0, dig1, dig2, dig3;
   logic        ovf, busy, upd_done;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   exp_t        q[$];
`ifdef DISP_LZB_EN
   localparam logic [15:0] RST_DIG = 16'hFFF0;
`else
   localparam logic [15:0] RST_DIG = 16'h0000;
`endif

   disp_bcd_ctrl #(.HOLD_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .value(value), .value_valid(value_valid),
      .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
      .ovf(ovf), .busy(busy), .upd_done(upd_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [16:0] model(input int v);
      logic [3:0] d3, d2, d1, d0;
      if (v > 9999) return {1'b1, 16'hFFFF};
      d3 = 4'(v / 1000);
      d2 = 4'((v / 100) % 10);
      d1 = 4'((v / 10) % 10);
      d0 = 4'(v % 10);
`ifdef DISP_LZB_EN
      if (v < 1000) d3 = 4'hF;
      if (v < 100) d2 = 4'hF;
      if (v < 10) d1 = 4'hF;
`endif
      return {1'b0, d3, d2, d1, d0};
   endfunction

   always @(negedge clk) begin
      if (!rst && upd_done) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_commit: cycle %0d digits %h ovf %b, none required", cyc, {dig3, dig2, dig1, dig0}, ovf);
         end else begin
            exp_t e;
            e = q.pop_front();
            if ({ovf, dig3, dig2, dig1, dig0} !== e.exp) begin
               errors++;
               $display("FAIL commit_value: got %h required %h", {ovf, dig3, dig2, dig1, dig0}, e.exp);
            end
            checks++;
            if (cyc !== e.due) begin
               errors++;
               $display("FAIL commit_cycle: got %0d required %0d", cyc, e.due);
            end
         end
      end
   end

   task automatic strobe_now(input int v, output int n);
      value = 14'(v);
      value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      n = cyc;
   endtask

   task automatic push(input int v, input int due);
      exp_t e;
      e.exp = model(v);
      e.due = due;
      q.push_back(e);
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic wait_idle();
      int k = 0;
      @(negedge clk);
      while ((busy || q.size() != 0) && k < 200) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (k >= 200) begin
         errors++;
         $display("FAIL idle_timeout: busy %b pending_expect %0d required idle", busy, q.size());
         q.delete();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if ({dig3, dig2, dig1, dig0} !== RST_DIG) begin
         errors++;
         $display("FAIL %s_digits: got %h required %h", tag, {dig3, dig2, dig1, dig0}, RST_DIG);
      end
      checks++;
      if ({ovf, busy, upd_done} !== 3'b000) begin
         errors++;
         $display("FAIL %s_flags: got ovf/busy/upd %b required 000", tag, {ovf, busy, upd_done});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int n;
      strobe_now(1234, n);
      push(1234, n + 15);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_start: got %b required 1", busy);
      end
      wait_cyc(n + 18);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_hold: got %b required 1", busy);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_end: got %b required 0", busy);
      end
      wait_idle();
   endtask

   task automatic test_values(input int vals[]);
      int n;
      foreach (vals[j]) begin
         @(negedge clk);
         strobe_now(vals[j], n);
         push(vals[j], n + 15);
         wait_idle();
      end
   endtask

   task automatic test_coalesce();
      int n, m;
      @(negedge clk);
      strobe_now(100, n);
      push(100, n + 15);
      strobe_now(200, m);
      strobe_now(300, m);
      push(300, n + 34);
      wait_idle();
   endtask

   task automatic test_exit_collision();
      int n, m;
      @(negedge clk);
      strobe_now(700, n);
      push(700, n + 15);
      strobe_now(500, m);
      wait_cyc(n + 18);
      strobe_now(600, m);
      push(600, m + 15);
      wait_idle();
      repeat (25) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL pending_cleared: busy %b required 0", busy);
      end
   endtask

   task automatic test_mid_reset();
      int n, m;
      @(negedge clk);
      strobe_now(1234, n);
      strobe_now(55, m);
      #2 rst = 1'b1;
      #1 check_reset_outputs("midreset");
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_idle: busy %b required 0", busy);
      end
      strobe_now(4321, n);
      push(4321, n + 15);
      wait_idle();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_values('{0, 9999, 10000, 16383});
      test_coalesce();
      test_exit_collision();
      test_values('{7, 1002, 40});
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
